// File: rtl/shift_reg_tx_ctrl.sv
// Parallel-to-serial transmit sequencer for an external right-shifting,
// zero-fill shift register. Accepts a byte over valid/ready, loads the
// register, streams WIDTH bits LSB-first with a per-bit valid strobe,
// pulses done after the last bit and supports mid-transfer abort.
// CNT_W must satisfy 2**CNT_W >= WIDTH.
module shift_reg_tx_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    input  logic             abort,
    output logic             sr_load,
    output logic [WIDTH-1:0] sr_d_in,
    output logic             sr_reset,
    input  logic             sr_q_lsb,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Counter value seen on the edge that shifts out the final payload bit.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    // State and bit counter registers; reset returns to IDLE on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Next-state logic and all outputs (outputs are decoded from the current
    // state so the serial bit lines up with the shift register's bit 0).
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_ready  = 1'b0;
        sr_load   = 1'b0;
        sr_d_in   = tx_data;
        sr_reset  = reset;
        ser_bit   = 1'b0;
        ser_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_ready = !reset;
                sr_load  = tx_valid && !reset;
                if (tx_valid) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                end
            end

            ST_SHIFT: begin
                ser_valid = 1'b1;
                ser_bit   = sr_q_lsb;
                busy      = 1'b1;
                if (abort) begin
                    // Clear the shift register now; abort beats the last-bit edge.
                    sr_reset  = 1'b1;
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end else if (bit_cnt_q == LAST_BIT) begin
                    state_d   = ST_DONE;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_reg_tx_ctrl.sv
// Bench for shift_reg_tx_ctrl: a behavioural 8-bit shift register sits
// alongside the controller; a table of per-cycle vectors covers reset,
// two full transfers and ignored abort/valid, and hand sequences cover
// abort, back-to-back accepts, reset mid-transfer and abort on the last bit.
module tb_shift_reg_tx_ctrl;

    localparam int WIDTH = 8;

    logic             clock;
    logic             reset;
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic             abort;
    logic             sr_load;
    logic [WIDTH-1:0] sr_d_in;
    logic             sr_reset;
    logic             sr_q_lsb;
    logic             ser_bit;
    logic             ser_valid;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sr_q;

    int errors = 0;
    int checks = 0;

    shift_reg_tx_ctrl #(.WIDTH(WIDTH), .CNT_W(3)) dut (
        .clock    (clock),
        .reset    (reset),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .abort    (abort),
        .sr_load  (sr_load),
        .sr_d_in  (sr_d_in),
        .sr_reset (sr_reset),
        .sr_q_lsb (sr_q_lsb),
        .ser_bit  (ser_bit),
        .ser_valid(ser_valid),
        .busy     (busy),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Shift register: synchronous reset, load priority, right shift zero-fill.
    always_ff @(posedge clock) begin
        if (sr_reset)     sr_q <= '0;
        else if (sr_load) sr_q <= sr_d_in;
        else              sr_q <= sr_q >> 1;
    end
    assign sr_q_lsb = sr_q[0];

    typedef struct packed {
        logic       rst;
        logic       vld;
        logic       abt;
        logic [7:0] data;
        logic       rdy;
        logic       ld;
        logic       sv;
        logic       sb;
        logic       bsy;
        logic       dn;
        logic       srr;
        logic [7:0] q;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic vld, input logic abt, input logic [7:0] data,
                       input logic rdy, input logic ld, input logic sv, input logic sb,
                       input logic bsy, input logic dn, input logic srr, input logic [7:0] q);
        vec_t v;
        v = '{rst, vld, abt, data, rdy, ld, sv, sb, bsy, dn, srr, q};
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, then wait for the
    // falling edge so outputs are sampled mid-cycle.
    task automatic step(input logic rst, input logic vld, input logic abt, input logic [7:0] data);
        @(posedge clock);
        #1;
        reset    = rst;
        tx_valid = vld;
        abort    = abt;
        tx_data  = data;
        @(negedge clock);
    endtask

    initial begin
        int acc_cyc[2];
        int nacc;
        int nbits;
        logic [15:0] bits;
        logic [7:0]  cur_data;
        logic        cur_vld;
        logic [7:0]  q_after2;
        int          errs_before;

        reset    = 1'b1;
        tx_valid = 1'b0;
        abort    = 1'b0;
        tx_data  = 8'h00;

        //   rst vld abt data   rdy ld sv sb bsy dn srr q
        add(1, 0, 0, 8'h00,  0, 0, 0, 0, 0, 0, 1, 8'h00); // reset held
        add(0, 0, 0, 8'h00,  1, 0, 0, 0, 0, 0, 0, 8'h00); // first cycle after reset
        add(0, 0, 1, 8'h00,  1, 0, 0, 0, 0, 0, 0, 8'h00); // abort in IDLE ignored
        add(0, 1, 0, 8'h55,  1, 1, 0, 0, 0, 0, 0, 8'h00); // accept 0x55
        add(0, 0, 0, 8'h00,  0, 0, 1, 1, 1, 0, 0, 8'h55);
        add(0, 0, 0, 8'h00,  0, 0, 1, 0, 1, 0, 0, 8'h2A);
        add(0, 1, 0, 8'h99,  0, 0, 1, 1, 1, 0, 0, 8'h15); // valid in SHIFT: no load
        add(0, 0, 0, 8'h00,  0, 0, 1, 0, 1, 0, 0, 8'h0A);
        add(0, 0, 0, 8'h00,  0, 0, 1, 1, 1, 0, 0, 8'h05);
        add(0, 0, 0, 8'h00,  0, 0, 1, 0, 1, 0, 0, 8'h02);
        add(0, 0, 0, 8'h00,  0, 0, 1, 1, 1, 0, 0, 8'h01);
        add(0, 0, 0, 8'h00,  0, 0, 1, 0, 1, 0, 0, 8'h00);
        add(0, 0, 1, 8'h00,  0, 0, 0, 0, 1, 1, 0, 8'h00); // DONE; abort ignored
        add(0, 1, 0, 8'hCC,  1, 1, 0, 0, 0, 0, 0, 8'h00); // ready again, accept 0xCC
        add(0, 0, 0, 8'h00,  0, 0, 1, 0, 1, 0, 0, 8'hCC);
        add(0, 0, 0, 8'h00,  0, 0, 1, 0, 1, 0, 0, 8'h66);
        add(0, 0, 0, 8'h00,  0, 0, 1, 1, 1, 0, 0, 8'h33);
        add(0, 0, 0, 8'h00,  0, 0, 1, 1, 1, 0, 0, 8'h19);
        add(0, 0, 0, 8'h00,  0, 0, 1, 0, 1, 0, 0, 8'h0C);
        add(0, 0, 0, 8'h00,  0, 0, 1, 0, 1, 0, 0, 8'h06);
        add(0, 0, 0, 8'h00,  0, 0, 1, 1, 1, 0, 0, 8'h03);
        add(0, 0, 0, 8'h00,  0, 0, 1, 1, 1, 0, 0, 8'h01);
        add(0, 0, 0, 8'h00,  0, 0, 0, 0, 1, 1, 0, 8'h00); // done pulse
        add(0, 0, 0, 8'h00,  1, 0, 0, 0, 0, 0, 0, 8'h00); // back in IDLE

        @(posedge clock);

        for (int i = 0; i < tbl.size(); i++) begin
            errs_before = errors;
            step(tbl[i].rst, tbl[i].vld, tbl[i].abt, tbl[i].data);
            chk($sformatf("row%0d tx_ready", i),  tx_ready,  tbl[i].rdy);
            chk($sformatf("row%0d sr_load", i),   sr_load,   tbl[i].ld);
            chk($sformatf("row%0d ser_valid", i), ser_valid, tbl[i].sv);
            chk($sformatf("row%0d ser_bit", i),   ser_bit,   tbl[i].sb);
            chk($sformatf("row%0d busy", i),      busy,      tbl[i].bsy);
            chk($sformatf("row%0d done", i),      done,      tbl[i].dn);
            chk($sformatf("row%0d sr_reset", i),  sr_reset,  tbl[i].srr);
            chk($sformatf("row%0d sr_q", i),      sr_q,      tbl[i].q);
            if (tbl[i].ld)
                chk($sformatf("row%0d sr_d_in", i), sr_d_in, tbl[i].data);
            $display("vec %0d: rst=%0b vld=%0b abt=%0b data=%02h -> rdy=%0b ld=%0b sv=%0b sb=%0b busy=%0b done=%0b srr=%0b q=%02h (%0d new errors)",
                     i, tbl[i].rst, tbl[i].vld, tbl[i].abt, tbl[i].data, tx_ready, sr_load,
                     ser_valid, ser_bit, busy, done, sr_reset, sr_q, errors - errs_before);
        end

        // Abort 0xFF during its 3rd bit cycle.
        step(0, 1, 0, 8'hFF);
        chk("abort accept sr_load", sr_load, 1'b1);
        step(0, 0, 0, 8'h00);
        chk("abort bit1 ser_bit", ser_bit, 1'b1);
        step(0, 0, 0, 8'h00);
        chk("abort bit2 sr_q", sr_q, 8'h7F);
        step(0, 0, 1, 8'h00);
        chk("abort bit3 ser_valid", ser_valid, 1'b1);
        chk("abort bit3 sr_reset", sr_reset, 1'b1);
        step(0, 0, 0, 8'h00);
        chk("abort after sr_reset", sr_reset, 1'b0);
        chk("abort after busy", busy, 1'b0);
        chk("abort after ser_valid", ser_valid, 1'b0);
        chk("abort after done", done, 1'b0);
        chk("abort after tx_ready", tx_ready, 1'b1);
        chk("abort after sr_q", sr_q, 8'h00);
        step(0, 0, 0, 8'h00);
        chk("abort later done", done, 1'b0);
        $display("seq abort 0xFF at bit 3: errors so far %0d", errors);

        // Back-to-back with tx_valid held: 0xA5 then 0x3C.
        nacc     = 0;
        nbits    = 0;
        bits     = '0;
        cur_data = 8'hA5;
        cur_vld  = 1'b1;
        q_after2 = 8'h00;
        acc_cyc[0] = -1;
        acc_cyc[1] = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            step(0, cur_vld, 0, cur_data);
            if (nacc == 2 && cyc == acc_cyc[1] + 1) q_after2 = sr_q;
            if (ser_valid && nbits < 16) begin
                bits[nbits] = ser_bit;
                nbits++;
            end
            if (sr_load) begin
                if (nacc < 2) acc_cyc[nacc] = cyc;
                nacc++;
            end
            if (nacc == 1) cur_data = 8'h3C;
            if (nacc >= 2) cur_vld = 1'b0;
        end
        chk("b2b accept count", nacc, 2);
        chk("b2b accept spacing", acc_cyc[1] - acc_cyc[0], 10);
        chk("b2b bit count", nbits, 16);
        chk("b2b bit stream", bits, 16'h3CA5);
        chk("b2b second load sr_q", q_after2, 8'h3C);
        $display("seq back-to-back A5/3C: accepts at %0d,%0d bits=%04h", acc_cyc[0], acc_cyc[1], bits);

        // Reset asserted during the 5th bit of 0x81.
        step(0, 1, 0, 8'h81);
        chk("rst accept sr_load", sr_load, 1'b1);
        for (int k = 1; k <= 4; k++) step(0, 0, 0, 8'h00);
        chk("rst bit4 sr_q", sr_q, 8'h10);
        step(1, 0, 0, 8'h00);
        chk("rst bit5 ser_valid", ser_valid, 1'b1);
        chk("rst bit5 sr_reset", sr_reset, 1'b1);
        chk("rst bit5 tx_ready", tx_ready, 1'b0);
        step(0, 0, 0, 8'h00);
        chk("rst after busy", busy, 1'b0);
        chk("rst after ser_valid", ser_valid, 1'b0);
        chk("rst after done", done, 1'b0);
        chk("rst after sr_q", sr_q, 8'h00);
        chk("rst after tx_ready", tx_ready, 1'b1);
        $display("seq reset at bit 5 of 0x81: errors so far %0d", errors);

        // Abort coinciding with the last-bit edge of 0x0F.
        step(0, 1, 0, 8'h0F);
        for (int k = 1; k <= 7; k++) step(0, 0, 0, 8'h00);
        step(0, 0, 1, 8'h00);
        chk("lastabort bit8 ser_valid", ser_valid, 1'b1);
        chk("lastabort bit8 sr_reset", sr_reset, 1'b1);
        step(0, 0, 0, 8'h00);
        chk("lastabort after done", done, 1'b0);
        chk("lastabort after busy", busy, 1'b0);
        chk("lastabort after tx_ready", tx_ready, 1'b1);
        $display("seq abort on last bit of 0x0F: errors so far %0d", errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
